mem_responder: RTL and testbench
================================

Name: mem_responder

Overview:
- Memory-side responder for the single-port data memory used by the memory-design lab.
- Accepts read and write requests from an initiator (CPU datapath or bench) over a valid/ready request channel.
- Performs each access on an internal 64x32 synchronous RAM with byte enables.
- Returns exactly one response per request over a valid/ready response channel, with backpressure support and access counters.

Parameters:
- ADDR_W, 6, word-address width.
- DATA_W, 32, data width; must be a multiple of 8.
- DEPTH, 64, number of implemented words; must be ≤ 2^ADDR_W.
- CNT_W, 16, width of the saturating access counters.

Ports:
- clka  in  1  clock; all logic on rising edge.
- rsta  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request this cycle.
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  word address.
- req_wdata  in  DATA_W  write data.
- req_be  in  DATA_W/8  byte enables, used for writes only.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  initiator accepts the response.
- rsp_rdata  out  DATA_W  read data, or post-write word for writes.
- rsp_we  out  1  echo of req_we.
- rsp_addr  out  ADDR_W  echo of req_addr.
- rsp_err  out  1  address ≥ DEPTH.
- rd_count  out  CNT_W  accepted reads, saturating.
- wr_count  out  CNT_W  accepted writes, saturating.

Behaviour:
- One clock (clka); reset rsta is synchronous and active-high.
- Reset values:
  - rsp_valid=0, rsp_rdata=0, rsp_we=0, rsp_addr=0, rsp_err=0.
  - rd_count=0, wr_count=0.
  - req_ready=0 while rsta=1.
- RAM contents are not touched by reset and are zero at time 0.
- Handshakes:
  - A request is accepted at an edge where req_valid && req_ready.
  - A response is consumed at an edge where rsp_valid && rsp_ready.
- req_ready = !rsta && (!rsp_valid || rsp_ready). This is combinational and allows one-per-cycle throughput with zero bubbles.
- State machine with two states:
  - EMPTY → FULL on accept.
  - FULL → FULL on consume+accept in the same edge.
  - FULL → EMPTY on consume with no accept.
  - FULL holds while rsp_ready=0.
  - rsp_valid = (state==FULL).
- Latency: a request accepted at edge N produces its response visible after edge N (one-cycle latency, same as the block RAM registered read).
- While stalled (rsp_valid=1, rsp_ready=0):
  - All rsp_* outputs hold stable.
  - No request is accepted.
  - The RAM is not accessed.
- Read: rsp_rdata = mem[req_addr].
- Write (write-first):
  - For each byte i with req_be[i]=1, mem byte i ← req_wdata byte i.
  - rsp_rdata = the resulting merged word.
  - be=0 is legal: no change; the current word is returned.
- Out of range (req_addr ≥ DEPTH):
  - No RAM write.
  - rsp_rdata=0, rsp_err=1.
  - Still counted.
  - Never blocks the handshake.
- Counters:
  - rd_count increments on each accepted read; wr_count on each accepted write.
  - Both saturate at 2^CNT_W−1 (no wrap).
- Read after write to the same address on consecutive accepts returns the new data (no hazard).
- rsta asserted mid-operation:
  - A pending response is dropped.
  - No request is accepted that cycle, so no write is performed.
  - The RAM keeps its prior contents.
- req_* inputs are ignored when req_valid=0. X on req_wdata with req_valid=0 must not propagate.

Decomposition:
- Package mem_resp_pkg holds:
  - ADDR_W, DATA_W, BE_W=DATA_W/8, CNT_W defaults.
  - The state enum {EMPTY, FULL}.
  - A packed response struct {err, we, addr, rdata}.
- One sub-module, ram_sp_be:
  - Single-port array of DEPTH×DATA_W with per-byte write enables and write-first registered read.
  - Ports: clka, en, we, be, addr, din, dout.
- The top level holds the handshake FSM, address-range check, response register, and counters.

Test Plan:
- Reset, then read addrs 0–9 with rsp_ready=1 → rsp_rdata=0 each, rsp_err=0, one response per cycle; rd_count=10.
- Write addrs 0–15 with data 0x1..0x10 and be=4'hF, then read back 0–15 → rsp_rdata=0x1..0x10 in order; wr_count=16, rd_count=16.
- Write 0xAABBCCDD to addr 3 with be=4'b0101, after addr 3 held 0x4 → write rsp_rdata=0x00BB00DD; a subsequent read of addr 3 returns 0x00BB00DD.
- Hold rsp_ready=0 for 3 cycles after a read of addr 1 → rsp_valid=1, rsp_rdata=0x2 stable, req_ready=0. Release → consumed and the next request accepted the same edge.
- DEPTH=48: read addr 50 → rsp_err=1, rsp_rdata=0. Write addr 50 → rsp_err=1, RAM unchanged (verified by full readback).
- Assert rsta one cycle while a write to addr 5 (0xDEAD) is presented and a response is pending → rsp_valid=0, counters=0, addr 5 still holds 0x6. Also cover CNT_W=4 with 20 reads → rd_count=15.

Source files
------------

// File: rtl/mem_resp_pkg.sv
// Shared widths, handshake state encoding and response layout for the
// memory responder and its single-port byte-enable RAM.
package mem_resp_pkg;

  localparam int DEF_ADDR_W = 6;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_BE_W   = DEF_DATA_W / 8;
  localparam int DEF_CNT_W  = 16;
  localparam int DEF_DEPTH  = 64;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  typedef struct packed {
    logic                  err;
    logic                  we;
    logic [DEF_ADDR_W-1:0] addr;
    logic [DEF_DATA_W-1:0] rdata;
  } rsp_t;

endpackage

// File: rtl/ram_sp_be.sv
// Single-port DEPTH x DATA_W RAM with per-byte write enables and a
// write-first registered read port; dout holds whenever en is low.
module ram_sp_be #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 64,
  parameter int BE_W   = DATA_W / 8
) (
  input  logic              clka,
  input  logic              en,
  input  logic              we,
  input  logic [BE_W-1:0]   be,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_dout;
  logic [DATA_W-1:0] w_merged;

  // Old word with enabled bytes replaced; also the write-first read value.
  always_comb begin
    w_merged = r_mem[addr];
    for (int i = 0; i < BE_W; i++) begin
      if (be[i]) begin
        w_merged[8*i +: 8] = din[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clka) begin
    if (en) begin
      if (we) begin
        r_mem[addr] <= w_merged;
        r_dout      <= w_merged;
      end else begin
        r_dout      <= r_mem[addr];
      end
    end
  end

  assign dout = r_dout;

endmodule

// File: rtl/mem_responder.sv
// Valid/ready request/response front end for the lab data memory: one
// response per request, one-cycle latency, range check and access counters.
//   state | meaning
//   EMPTY | no response held; a request may be accepted
//   FULL  | response held on rsp_*; waits for rsp_ready
module mem_responder
  import mem_resp_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int CNT_W  = DEF_CNT_W,
  parameter int BE_W   = DATA_W / 8
) (
  input  logic              clka,
  input  logic              rsta,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [BE_W-1:0]   req_be,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_we,
  output logic [ADDR_W-1:0] rsp_addr,
  output logic              rsp_err,
  output logic [CNT_W-1:0]  rd_count,
  output logic [CNT_W-1:0]  wr_count
);

  localparam int           DEPTH_W = ADDR_W + 1;
  localparam [DEPTH_W-1:0] DEPTH_L = DEPTH_W'(DEPTH);

  state_t              r_state;
  logic                r_err;
  logic                r_we;
  logic [ADDR_W-1:0]   r_addr;
  logic                r_rd_ok;
  logic [CNT_W-1:0]    r_rd_cnt;
  logic [CNT_W-1:0]    r_wr_cnt;

  logic                w_accept;
  logic                w_consume;
  logic                w_in_range;
  logic [DATA_W-1:0]   w_dout;

  assign rsp_valid  = (r_state == FULL);
  assign req_ready  = !rsta && (!rsp_valid || rsp_ready);
  assign w_accept   = req_valid && req_ready;
  assign w_consume  = rsp_valid && rsp_ready;
  assign w_in_range = ({1'b0, req_addr} < DEPTH_L);

  // RAM is only touched on an accepted, in-range request, so a stall or an
  // idle X-laden bus never reaches the array or the read register.
  ram_sp_be #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .BE_W   (BE_W)
  ) u_ram (
    .clka (clka),
    .en   (w_accept && w_in_range),
    .we   (req_we),
    .be   (req_be),
    .addr (req_addr),
    .din  (req_wdata),
    .dout (w_dout)
  );

  always_ff @(posedge clka) begin
    if (rsta) begin
      r_state <= EMPTY;
    end else begin
      case (r_state)
        EMPTY:   if (w_accept) r_state <= FULL;
        FULL:    if (w_consume && !w_accept) r_state <= EMPTY;
        default: r_state <= EMPTY;
      endcase
    end
  end

  always_ff @(posedge clka) begin
    if (rsta) begin
      r_err   <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_rd_ok <= 1'b0;
    end else if (w_accept) begin
      r_err   <= !w_in_range;
      r_we    <= req_we;
      r_addr  <= req_addr;
      r_rd_ok <= w_in_range;
    end
  end

  always_ff @(posedge clka) begin
    if (rsta) begin
      r_rd_cnt <= '0;
      r_wr_cnt <= '0;
    end else if (w_accept) begin
      if (req_we) begin
        if (r_wr_cnt != '1) r_wr_cnt <= r_wr_cnt + 1'b1;
      end else begin
        if (r_rd_cnt != '1) r_rd_cnt <= r_rd_cnt + 1'b1;
      end
    end
  end

  // RAM output is not reset; mask it so reset and error responses read 0.
  assign rsp_rdata = r_rd_ok ? w_dout : '0;
  assign rsp_we    = r_we;
  assign rsp_addr  = r_addr;
  assign rsp_err   = r_err;
  assign rd_count  = r_rd_cnt;
  assign wr_count  = r_wr_cnt;

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: directed requests push expected
// responses; a negedge monitor pops and compares on every consume.
module tb_mem_responder;
  import mem_resp_pkg::*;

  logic        clka = 1'b0;
  logic        rsta;
  logic        req_valid, req_we, rsp_ready;
  logic [5:0]  req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        req_ready, rsp_valid, rsp_we, rsp_err;
  logic [31:0] rsp_rdata;
  logic [5:0]  rsp_addr;
  logic [15:0] rd_count, wr_count;

  logic        s_req_valid, s_req_ready, s_rsp_valid, s_rsp_we, s_rsp_err;
  logic [31:0] s_rsp_rdata;
  logic [5:0]  s_rsp_addr;
  logic [3:0]  s_rd_count, s_wr_count;

  rsp_t exp_q[$];
  int   n_chk = 0;
  int   n_err = 0;
  int   cyc   = 0;
  int   rd_exp = 0;
  int   wr_exp = 0;

  always #5 clka = ~clka;
  always @(posedge clka) cyc <= cyc + 1;

  mem_responder #(.DEPTH(48)) dut (
    .clka(clka), .rsta(rsta),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_we(rsp_we), .rsp_addr(rsp_addr), .rsp_err(rsp_err),
    .rd_count(rd_count), .wr_count(wr_count)
  );

  mem_responder #(.CNT_W(4)) u_sat (
    .clka(clka), .rsta(rsta),
    .req_valid(s_req_valid), .req_ready(s_req_ready), .req_we(1'b0),
    .req_addr(6'd0), .req_wdata(32'd0), .req_be(4'h0),
    .rsp_valid(s_rsp_valid), .rsp_ready(1'b1), .rsp_rdata(s_rsp_rdata),
    .rsp_we(s_rsp_we), .rsp_addr(s_rsp_addr), .rsp_err(s_rsp_err),
    .rd_count(s_rd_count), .wr_count(s_wr_count)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clka) begin
    if (!rsta && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_err++;
        $display("FAIL unexpected_rsp: got addr %0h data %0h with no pending request", rsp_addr, rsp_rdata);
      end else begin
        rsp_t e;
        e = exp_q.pop_front();
        chk("rsp", {24'd0, rsp_err, rsp_we, rsp_addr, rsp_rdata}, {24'd0, e});
      end
    end
  end

  task automatic send(input logic we, input logic [5:0] addr, input logic [31:0] wd,
                      input logic [3:0] be, input logic [31:0] exp_d, input logic exp_err);
    rsp_t e;
    bit   accepted;
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd; req_be = be;
    accepted = 1'b0;
    for (int k = 0; k < 50 && !accepted; k++) begin
      @(negedge clka);
      if (req_ready) begin
        e.err = exp_err; e.we = we; e.addr = addr; e.rdata = exp_d;
        exp_q.push_back(e);
        accepted = 1'b1;
      end
      @(posedge clka); #1;
    end
    n_chk++;
    if (!accepted) begin
      n_err++;
      $display("FAIL accept_timeout: addr %0h not accepted within 50 cycles", addr);
    end
    if (we) wr_exp++; else rd_exp++;
  endtask

  task automatic idle(input int n);
    req_valid = 1'b0; req_we = 1'b0; req_wdata = 'x; req_be = 'x;
    repeat (n) begin @(posedge clka); #1; end
  endtask

  task automatic chk_counts(input string tag);
    @(negedge clka);
    chk({tag, "_rd_count"}, 64'(rd_count), 64'(rd_exp));
    chk({tag, "_wr_count"}, 64'(wr_count), 64'(wr_exp));
    @(posedge clka); #1;
  endtask

  task automatic do_reset();
    rsta = 1'b1;
    @(posedge clka); #1;
    rsta = 1'b0;
    exp_q.delete();
    rd_exp = 0; wr_exp = 0;
  endtask

  function automatic logic [31:0] model_word(input int a);
    if (a == 3)  return 32'h00BB00DD;
    if (a < 16)  return 32'(a + 1);
    if (a == 47) return 32'h47;
    return 32'h0;
  endfunction

  initial begin
    int t0;
    rsta = 1'b1; rsp_ready = 1'b1; s_req_valid = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = 'x; req_be = '0;
    repeat (3) @(posedge clka);
    @(negedge clka);
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_rsp_fields", {24'd0, rsp_err, rsp_we, rsp_addr, rsp_rdata}, 64'd0);
    chk("rst_counts", {32'd0, rd_count, wr_count}, 64'd0);
    @(posedge clka); #1;
    rsta = 1'b0;

    // Fresh RAM reads as zero, back to back.
    t0 = cyc;
    for (int a = 0; a < 10; a++) send(1'b0, 6'(a), 32'd0, 4'h0, 32'd0, 1'b0);
    chk("throughput_cycles", 64'(cyc - t0), 64'd10);
    idle(2);
    chk_counts("p1");

    do_reset();
    for (int a = 0; a < 16; a++) send(1'b1, 6'(a), 32'(a + 1), 4'hF, 32'(a + 1), 1'b0);
    for (int a = 0; a < 16; a++) send(1'b0, 6'(a), 32'd0, 4'h0, 32'(a + 1), 1'b0);
    idle(2);
    chk_counts("p2");

    send(1'b1, 6'd3, 32'hAABBCCDD, 4'b0101, 32'h00BB00DD, 1'b0);
    send(1'b0, 6'd3, 32'd0, 4'h0, 32'h00BB00DD, 1'b0);
    send(1'b1, 6'd7, 32'hFFFFFFFF, 4'h0, 32'h8, 1'b0);
    send(1'b0, 6'd7, 32'd0, 4'h0, 32'h8, 1'b0);
    idle(2);

    // Backpressure: response to read of addr 1 must hold for 3 cycles.
    rsp_ready = 1'b0;
    send(1'b0, 6'd1, 32'd0, 4'h0, 32'h2, 1'b0);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 6'd2;
    for (int k = 0; k < 3; k++) begin
      @(negedge clka);
      chk("stall_rsp_valid", 64'(rsp_valid), 64'd1);
      chk("stall_rsp_rdata", 64'(rsp_rdata), 64'h2);
      chk("stall_req_ready", 64'(req_ready), 64'd0);
      @(posedge clka); #1;
    end
    rsp_ready = 1'b1;
    #1;
    chk("release_req_ready", 64'(req_ready), 64'd1);
    send(1'b0, 6'd2, 32'd0, 4'h0, 32'h3, 1'b0);
    idle(2);

    // Out-of-range accesses and the last valid word.
    send(1'b0, 6'd50, 32'd0, 4'h0, 32'd0, 1'b1);
    send(1'b1, 6'd50, 32'h12345678, 4'hF, 32'd0, 1'b1);
    send(1'b0, 6'd48, 32'd0, 4'h0, 32'd0, 1'b1);
    send(1'b0, 6'd63, 32'd0, 4'h0, 32'd0, 1'b1);
    send(1'b1, 6'd47, 32'h47, 4'hF, 32'h47, 1'b0);
    for (int a = 0; a < 48; a++) send(1'b0, 6'(a), 32'd0, 4'h0, model_word(a), 1'b0);
    idle(2);
    chk_counts("p5");

    // Reset while a response is pending and a write is presented.
    rsp_ready = 1'b0;
    send(1'b0, 6'd0, 32'd0, 4'h0, 32'h1, 1'b0);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 6'd5; req_wdata = 32'hDEAD; req_be = 4'hF;
    rsta = 1'b1;
    @(negedge clka);
    chk("rst_mid_req_ready", 64'(req_ready), 64'd0);
    @(posedge clka); #1;
    rsta = 1'b0; req_valid = 1'b0;
    exp_q.delete();
    rd_exp = 0; wr_exp = 0;
    @(negedge clka);
    chk("rst_mid_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_mid_counts", {32'd0, rd_count, wr_count}, 64'd0);
    @(posedge clka); #1;
    rsp_ready = 1'b1;
    send(1'b0, 6'd5, 32'd0, 4'h0, 32'h6, 1'b0);
    idle(2);
    chk_counts("p6");

    // Saturation on the CNT_W=4 instance.
    s_req_valid = 1'b1;
    repeat (15) @(posedge clka);
    #1 s_req_valid = 1'b0;
    @(negedge clka);
    chk("sat_rd_count_15", 64'(s_rd_count), 64'd15);
    @(posedge clka); #1;
    s_req_valid = 1'b1;
    repeat (5) @(posedge clka);
    #1 s_req_valid = 1'b0;
    @(negedge clka);
    chk("sat_rd_count_20", 64'(s_rd_count), 64'd15);
    chk("sat_wr_count", 64'(s_wr_count), 64'd0);

    for (int k = 0; k < 20 && exp_q.size() != 0; k++) @(negedge clka);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
